des_cbc_chain: RTL

- Chaining stage between the block RAM sequencer and the DES core, clocked on clk1.
- Accepts 64-bit blocks over a valid/ready handshake and applies CBC chaining (XOR with IV or the previous block).
- Drives the DES core's desIn, roundSel and decrypt inputs, then samples desOut after round 15.
- Returns the chained result over a second valid/ready handshake. With cbc_en=0 it is a pass-through ECB sequencer.

---
 rtl/des_cbc_chain_pkg.sv | 16 +
 rtl/des_cbc_chain_if.sv | 22 ++
 rtl/des_cbc_chain.sv | 131 +++++++++++++
 3 files changed

// File: rtl/des_cbc_chain_pkg.sv
// Shared constants and state encoding for the DES CBC chaining stage.
package des_pkg;

    localparam int unsigned DES_BLK_W   = 64;
    localparam int unsigned DES_ROUND_W = 4;
    localparam logic [DES_ROUND_W-1:0] DES_LAST_ROUND = 4'd15;

    typedef logic [DES_BLK_W-1:0] blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/des_cbc_chain_if.sv
// Block stream handshake between the RAM sequencer, the chaining stage and its consumer.
interface des_cbc_chain_if;
    import des_pkg::*;

    logic in_valid;
    logic in_ready;
    blk_t in_data;
    logic out_valid;
    logic out_ready;
    blk_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/des_cbc_chain.sv
// CBC/ECB chaining stage: feeds one block at a time through the DES core rounds
// and returns the chained result over a valid/ready handshake.
module des_cbc_chain
    import des_pkg::*;
#(
    parameter int unsigned BLK_W = DES_BLK_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk1,
    input  logic                   reset,
    input  logic                   cbc_en,
    input  logic                   decrypt,
    input  logic [BLK_W-1:0]       iv,
    input  logic                   iv_load,
    des_cbc_chain_if.slave         bus,
    output logic [BLK_W-1:0]       des_in,
    output logic [DES_ROUND_W-1:0] des_round_sel,
    output logic                   des_decrypt,
    input  logic [BLK_W-1:0]       des_out,
    output logic                   busy,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   iv_err
);

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             last_round;
    logic             deliver;
    logic             m_dec;
    logic             m_cbc;
    logic [BLK_W-1:0] chain;
    logic [BLK_W-1:0] blk_in;
    logic [BLK_W-1:0] out_data;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        last_round    = 1'b0;
        deliver       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = out_data;
        busy          = (state != IDLE);
        des_decrypt   = m_dec;
        case (state)
            IDLE: begin
                // An IV load owns the chain register this cycle, so no block may enter.
                bus.in_ready = !iv_load && !reset;
                if (bus.in_valid && !iv_load && !reset) begin
                    accept   = 1'b1;
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                if (des_round_sel == DES_LAST_ROUND) begin
                    last_round = 1'b1;
                    state_nx   = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    deliver  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            m_dec         <= 1'b0;
            m_cbc         <= 1'b0;
            chain         <= '0;
            blk_in        <= '0;
            out_data      <= '0;
            des_in        <= '0;
            des_round_sel <= '0;
            blk_count     <= '0;
            iv_err        <= 1'b0;
        end else begin
            if (iv_load) begin
                if (state == IDLE) begin
                    chain <= iv;
                end else begin
                    iv_err <= 1'b1;
                end
            end

            if (accept) begin
                m_dec         <= decrypt;
                m_cbc         <= cbc_en;
                blk_in        <= bus.in_data;
                des_in        <= (cbc_en && !decrypt) ? (bus.in_data ^ chain) : bus.in_data;
                des_round_sel <= '0;
            end else if (state == ROUND && !last_round) begin
                des_round_sel <= des_round_sel + DES_ROUND_W'(1);
            end

            // Decrypt chains on the ciphertext that came in; encrypt chains on what goes out.
            if (last_round) begin
                if (m_dec) begin
                    out_data <= m_cbc ? (des_out ^ chain) : des_out;
                    if (m_cbc) begin
                        chain <= blk_in;
                    end
                end else begin
                    out_data <= des_out;
                    if (m_cbc) begin
                        chain <= des_out;
                    end
                end
            end

            if (deliver) begin
                blk_count <= blk_count + CNT_W'(1);
            end
        end
    end

endmodule
